// File: rtl/hci_package.sv
// -----------------------------------------------------------------------------
// hci_package
//   Shared definitions for the HCI TCDM bank endpoint. It holds the default
//   widths and the test-and-set address bit. The interconnect and the bank
//   responder both parameterise from these values, so they stay consistent.
//   It also holds the state type of the bank responder FSM.
// -----------------------------------------------------------------------------
package hci_package;

    localparam int unsigned DEFAULT_DW     = 32;
    localparam int unsigned DEFAULT_BW     = 8;
    localparam int unsigned DEFAULT_UW     = 0;
    localparam int unsigned DEFAULT_TS_BIT = 21;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        TS_SET = 1'b1
    } hci_bank_state_e;

endpackage : hci_package

// File: rtl/hci_tcdm_bank_responder.sv
// -----------------------------------------------------------------------------
// hci_tcdm_bank_responder
//   Target-side endpoint for one TCDM bank port of the HCI log interconnect.
//   It forwards granted requests to an external single-port SRAM in the same
//   cycle. It returns exactly one response (r_valid/r_id/r_data) one cycle
//   after each grant. A read with add_i[TS_BIT] set is a test-and-set: the
//   first cycle reads the old value, and the following cycle (TS_SET) writes
//   TS_VALUE to the same word. No new request is granted during TS_SET.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i .. id_i       hci_core request stream (wen_i = 1 means read)
//   gnt_o               request accepted this cycle
//   r_valid_o .. r_id_o response, valid one cycle after the grant
//   mem_*_o             SRAM port; mem_wdata_o/mem_be_o carry {user,data}
//   mem_rdata_i         SRAM read word, valid one cycle after a read
// -----------------------------------------------------------------------------
module hci_tcdm_bank_responder
    import hci_package::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   MEM_AW   = 10,
    parameter int unsigned   DW       = DEFAULT_DW,
    parameter int unsigned   BW       = DEFAULT_BW,
    parameter int unsigned   UW       = DEFAULT_UW,
    parameter int unsigned   IW       = 20,
    parameter int unsigned   TS_BIT   = DEFAULT_TS_BIT,
    parameter logic [DW-1:0] TS_VALUE = '1,
    localparam int unsigned  UWP      = (UW > 0) ? UW : 1,
    localparam int unsigned  BEW      = DW / BW,
    localparam int unsigned  MW       = UW + DW,
    localparam int unsigned  MBEW     = MW / BW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [AW-1:0]     add_i,
    input  logic              wen_i,
    input  logic [DW-1:0]     data_i,
    input  logic [UWP-1:0]    user_i,
    input  logic [BEW-1:0]    be_i,
    input  logic [IW-1:0]     id_i,
    output logic              gnt_o,
    output logic              r_valid_o,
    output logic [DW-1:0]     r_data_o,
    output logic [UWP-1:0]    r_user_o,
    output logic [IW-1:0]     r_id_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [MEM_AW-1:0] mem_add_o,
    output logic [MW-1:0]     mem_wdata_o,
    output logic [MBEW-1:0]   mem_be_o,
    input  logic [MW-1:0]     mem_rdata_i
);

    hci_bank_state_e   state_q, state_d;
    logic [MEM_AW-1:0] ts_addr_q, ts_addr_d;
    logic              r_valid_q, r_valid_d;
    logic [IW-1:0]     r_id_q, r_id_d;

    logic              gnt;
    logic              mem_req;
    logic              mem_wen;
    logic [MEM_AW-1:0] mem_add;
    logic [DW-1:0]     wdata;
    logic [UWP-1:0]    wuser;
    logic [BEW-1:0]    be;
    logic [MW-1:0]     mem_wdata_full;
    logic [MBEW-1:0]   mem_be_full;
    logic [UWP-1:0]    r_user_full;

    // The word index ignores the byte offset, TS_BIT and all bits above the bank.
    logic [MEM_AW-1:0] word_addr;
    logic              is_ts;
    assign word_addr = add_i[2 +: MEM_AW];
    assign is_ts     = req_i & wen_i & add_i[TS_BIT];

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // a value unassigned and no latch is inferred.
        state_d   = state_q;
        ts_addr_d = ts_addr_q;
        r_valid_d = 1'b0;
        r_id_d    = r_id_q;      // id holds while no response is pending
        gnt       = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b1;
        mem_add   = word_addr;
        wdata     = data_i;
        wuser     = user_i;
        be        = be_i;

        case (state_q)
            IDLE: begin
                // The grant does not depend on req_i, so the initiator can rely on it.
                gnt     = 1'b1;
                mem_req = req_i;
                mem_wen = wen_i;
                if (req_i) begin
                    r_valid_d = 1'b1;
                    r_id_d    = id_i;
                end
                if (is_ts) begin
                    state_d   = TS_SET;
                    ts_addr_d = word_addr;
                end
            end
            TS_SET: begin
                // Set phase: overwrite the word just read. The held request
                // waits, and this write produces no response of its own.
                mem_req = 1'b1;
                mem_wen = 1'b0;
                mem_add = ts_addr_q;
                wdata   = TS_VALUE;
                wuser   = '0;
                be      = '1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ts_addr_q <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            ts_addr_q <= ts_addr_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

    // User sideband sits above the data. Its bytes are always enabled, so the
    // stored ECC stays consistent with the data.
    if (UW > 0) begin : g_user
        assign mem_wdata_full = {wuser, wdata};
        assign mem_be_full    = {{(UW / BW){1'b1}}, be};
        assign r_user_full    = mem_rdata_i[MW-1:DW];
    end else begin : g_no_user
        assign mem_wdata_full = wdata;
        assign mem_be_full    = be;
        assign r_user_full    = '0;
    end

    // Combinational outputs are forced low while reset is asserted. This keeps
    // a stray SRAM access or grant from escaping during reset. Once reset is
    // released they are live at once, so the first request is granted immediately.
    assign gnt_o       = rst_ni & gnt;
    assign mem_req_o   = rst_ni & mem_req;
    assign mem_wen_o   = rst_ni & mem_wen;
    assign mem_add_o   = rst_ni ? mem_add        : '0;
    assign mem_wdata_o = rst_ni ? mem_wdata_full : '0;
    assign mem_be_o    = rst_ni ? mem_be_full    : '0;
    assign r_data_o    = rst_ni ? mem_rdata_i[DW-1:0] : '0;
    assign r_user_o    = rst_ni ? r_user_full    : '0;
    assign r_valid_o   = r_valid_q;
    assign r_id_o      = r_id_q;

    // Address bits outside the word index and the user bits (when UW = 0) are
    // intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{add_i, user_i, wuser};

endmodule : hci_tcdm_bank_responder

// File: tb/tb_hci_tcdm_bank_responder.sv
// -----------------------------------------------------------------------------
// tb_hci_tcdm_bank_responder
//   Directed bench for the HCI TCDM bank responder with default parameters.
//   A behavioural single-port SRAM (1-cycle read latency, byte enables) is
//   attached to the mem_* port. Table vectors describe one clock cycle each:
//   the inputs driven in that cycle and the outputs expected in that cycle.
//   The r_* fields refer to the request of the previous cycle.
// -----------------------------------------------------------------------------
module tb_hci_tcdm_bank_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 20;
    localparam logic [AW-1:0] TS = 32'h0020_0000;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic [AW-1:0]     add_i = '0;
    logic              wen_i = 1'b1;
    logic [DW-1:0]     data_i = '0;
    logic [0:0]        user_i = '0;
    logic [3:0]        be_i = '0;
    logic [IW-1:0]     id_i = '0;
    logic              gnt_o, r_valid_o, mem_req_o, mem_wen_o;
    logic [DW-1:0]     r_data_o, mem_wdata_o;
    logic [0:0]        r_user_o;
    logic [IW-1:0]     r_id_o;
    logic [MEM_AW-1:0] mem_add_o;
    logic [3:0]        mem_be_o;
    logic [DW-1:0]     mem_rdata_i = '0;

    int n_tests = 0;
    int n_fail = 0;
    int n_grants = 0;
    int n_rvalid = 0;
    int n_writes = 0;

    hci_tcdm_bank_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i),
        .wen_i(wen_i), .data_i(data_i), .user_i(user_i), .be_i(be_i),
        .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .r_user_o(r_user_o), .r_id_o(r_id_o), .mem_req_o(mem_req_o),
        .mem_wen_o(mem_wen_o), .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM, preloaded with word index + 0x1000_0000.
    logic [DW-1:0] mem [1 << MEM_AW];
    initial for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h1000_0000 + i;

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_wen_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end else if (mem_req_o) begin
            mem_rdata_i <= mem[mem_add_o];
        end
    end

    // Protocol counters, sampled with pre-edge values.
    always @(posedge clk_i) begin
        if (rst_ni && req_i && gnt_o) n_grants++;
        if (r_valid_o) n_rvalid++;
        if (mem_req_o && !mem_wen_o) n_writes++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              req;
        logic [AW-1:0]     add;
        logic              wen;
        logic [DW-1:0]     data;
        logic [3:0]        be;
        logic [IW-1:0]     id;
        logic              gnt;
        logic              mreq;
        logic              mwen;
        logic [MEM_AW-1:0] madd;
        logic              chk_w;
        logic [DW-1:0]     wdata;
        logic [3:0]        mbe;
        logic              rvalid;
        logic              chk_d;
        logic [DW-1:0]     rdata;
        logic [IW-1:0]     rid;
    } vec_t;

    function automatic vec_t mk(
        input logic req, input logic [AW-1:0] add, input logic wen,
        input logic [DW-1:0] data, input logic [3:0] be, input logic [IW-1:0] id,
        input logic gnt, input logic mreq, input logic mwen, input logic [MEM_AW-1:0] madd,
        input logic chk_w, input logic [DW-1:0] wdata, input logic [3:0] mbe,
        input logic rvalid, input logic chk_d, input logic [DW-1:0] rdata,
        input logic [IW-1:0] rid);
        vec_t v;
        v.req = req; v.add = add; v.wen = wen; v.data = data; v.be = be; v.id = id;
        v.gnt = gnt; v.mreq = mreq; v.mwen = mwen; v.madd = madd;
        v.chk_w = chk_w; v.wdata = wdata; v.mbe = mbe;
        v.rvalid = rvalid; v.chk_d = chk_d; v.rdata = rdata; v.rid = rid;
        return v;
    endfunction

    task automatic drive(input logic req, input logic [AW-1:0] add, input logic wen,
                         input logic [DW-1:0] data, input logic [3:0] be, input logic [IW-1:0] id);
        req_i = req; add_i = add; wen_i = wen; data_i = data; be_i = be; id_i = id;
    endtask

    vec_t vecs [19];

    initial begin
        //                 req add          wen data          be     id  gnt mreq mwen madd  chk_w wdata         mbe    rv chk_d rdata         rid
        vecs[0]  = mk(1, 32'h40,      0, 32'hDEADBEEF, 4'hF, 5,  1, 1, 0, 10'h10, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0,             0);
        vecs[1]  = mk(1, 32'h40,      1, 0,            4'hF, 7,  1, 1, 1, 10'h10, 0, 0,            0,    1, 0, 0,             5);
        vecs[2]  = mk(0, 0,           1, 0,            0,    0,  1, 0, 0, 0,      0, 0,            0,    1, 1, 32'hDEADBEEF,  7);
        vecs[3]  = mk(1, 32'h80,      0, 32'h11223344, 4'hF, 1,  1, 1, 0, 10'h20, 0, 0,            0,    0, 0, 0,             7);
        vecs[4]  = mk(1, 32'h80,      0, 32'h0000AB00, 4'h2, 2,  1, 1, 0, 10'h20, 1, 32'h0000AB00, 4'h2, 1, 0, 0,             1);
        vecs[5]  = mk(1, 32'h80,      1, 0,            4'hF, 3,  1, 1, 1, 10'h20, 0, 0,            0,    1, 0, 0,             2);
        vecs[6]  = mk(0, 0,           1, 0,            0,    0,  1, 0, 0, 0,      0, 0,            0,    1, 1, 32'h1122AB44,  3);
        vecs[7]  = mk(1, 32'h40,      0, 32'h0,        4'hF, 4,  1, 1, 0, 10'h10, 0, 0,            0,    0, 0, 0,             3);
        vecs[8]  = mk(1, TS | 32'h40, 1, 0,            4'hF, 8,  1, 1, 1, 10'h10, 0, 0,            0,    1, 0, 0,             4);
        vecs[9]  = mk(0, 0,           1, 0,            0,    0,  0, 1, 0, 10'h10, 1, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0,         8);
        vecs[10] = mk(1, 32'h40,      1, 0,            4'hF, 9,  1, 1, 1, 10'h10, 0, 0,            0,    0, 0, 0,             8);
        vecs[11] = mk(0, 0,           1, 0,            0,    0,  1, 0, 0, 0,      0, 0,            0,    1, 1, 32'hFFFFFFFF,  9);
        vecs[12] = mk(1, TS | 32'h80, 0, 32'h55,       4'hF, 10, 1, 1, 0, 10'h20, 1, 32'h55,       4'hF, 0, 0, 0,             9);
        vecs[13] = mk(1, 32'h80,      1, 0,            4'hF, 11, 1, 1, 1, 10'h20, 0, 0,            0,    1, 0, 0,             10);
        vecs[14] = mk(0, 0,           1, 0,            0,    0,  1, 0, 0, 0,      0, 0,            0,    1, 1, 32'h55,        11);
        vecs[15] = mk(1, TS | 32'h80, 1, 0,            4'hF, 12, 1, 1, 1, 10'h20, 0, 0,            0,    0, 0, 0,             11);
        vecs[16] = mk(1, 32'h80,      1, 0,            4'hF, 13, 0, 1, 0, 10'h20, 1, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h55,        12);
        vecs[17] = mk(1, 32'h80,      1, 0,            4'hF, 13, 1, 1, 1, 10'h20, 0, 0,            0,    0, 0, 0,             12);
        vecs[18] = mk(0, 0,           1, 0,            0,    0,  1, 0, 0, 0,      0, 0,            0,    1, 1, 32'hFFFFFFFF,  13);

        // Reset state, with a request present to show nothing leaks out.
        drive(1, 32'h40, 0, 32'hCAFE, 4'hF, 3);
        #2;
        check("rst_gnt", gnt_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_wen", mem_wen_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_r_id", r_id_o, 0);
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            drive(vecs[i].req, vecs[i].add, vecs[i].wen, vecs[i].data, vecs[i].be, vecs[i].id);
            #1;
            check($sformatf("v%0d_gnt", i), gnt_o, vecs[i].gnt);
            check($sformatf("v%0d_mem_req", i), mem_req_o, vecs[i].mreq);
            if (vecs[i].mreq) begin
                check($sformatf("v%0d_mem_wen", i), mem_wen_o, vecs[i].mwen);
                check($sformatf("v%0d_mem_add", i), mem_add_o, vecs[i].madd);
            end
            if (vecs[i].chk_w) begin
                check($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].wdata);
                check($sformatf("v%0d_mem_be", i), mem_be_o, vecs[i].mbe);
            end
            check($sformatf("v%0d_r_valid", i), r_valid_o, vecs[i].rvalid);
            check($sformatf("v%0d_r_id", i), r_id_o, vecs[i].rid);
            if (vecs[i].chk_d) check($sformatf("v%0d_r_data", i), r_data_o, vecs[i].rdata);
        end

        // Eight back-to-back reads of words 0x40..0x47 (untouched preload values).
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
            drive(k < 8, 32'h100 + 4 * k, 1, 0, 4'hF, 20 + k);
            #1;
            if (k < 8) check($sformatf("b2b%0d_gnt", k), gnt_o, 1);
            if (k > 0) begin
                check($sformatf("b2b%0d_r_valid", k), r_valid_o, 1);
                check($sformatf("b2b%0d_r_id", k), r_id_o, 20 + k - 1);
                check($sformatf("b2b%0d_r_data", k), r_data_o, 32'h1000_0040 + k - 1);
            end
        end

        // Reset in the TS_SET cycle: the set write is abandoned.
        @(negedge clk_i);
        check("grants_eq_rvalids", n_grants, n_rvalid);
        drive(1, 32'h80, 0, 32'h12345678, 4'hF, 40);
        @(negedge clk_i);
        drive(1, TS | 32'h80, 1, 0, 4'hF, 41);
        #1;
        check("rts_gnt", gnt_o, 1);
        @(negedge clk_i);
        drive(0, 0, 1, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        begin
            int writes_before;
            writes_before = n_writes;
            check("rts_gnt_low", gnt_o, 0);
            check("rts_mem_req", mem_req_o, 0);
            check("rts_r_valid", r_valid_o, 0);
            check("rts_r_id", r_id_o, 0);
            check("rts_r_data", r_data_o, 0);
            check("rts_mem_be", mem_be_o, 0);
            @(negedge clk_i);
            check("rts_no_write", n_writes, writes_before);
        end
        rst_ni = 1'b1;
        drive(1, 32'h80, 1, 0, 4'hF, 42);
        #1;
        check("post_rst_gnt", gnt_o, 1);
        check("post_rst_mem_wen", mem_wen_o, 1);
        @(negedge clk_i);
        drive(0, 0, 1, 0, 0, 0);
        #1;
        check("post_rst_r_valid", r_valid_o, 1);
        check("post_rst_r_id", r_id_o, 42);
        check("post_rst_r_data", r_data_o, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hci_tcdm_bank_responder

// File: doc/hci_tcdm_bank_responder.md
Name: hci_tcdm_bank_responder

Overview:
- Target-side endpoint for one TCDM bank port of the HCI log interconnect.
- Accepts the hci_core request stream that the interconnect drives into a bank: req, add, wen, data, be, user, id.
- Drives a single-port SRAM macro and returns the bank's response: gnt, r_valid, r_data, r_user, r_id.
- Generates the interconnect's r_valid/r_id locally and executes the test-and-set (TS) read-modify-write in the bank.

Parameters:
- AW, 32: request address width (byte address as delivered by the interconnect).
- MEM_AW, 10: SRAM word-address width; word index = add_i[2 +: MEM_AW].
- DW, 32: data width.
- BW, 8: byte width; byte-enable width is DW/BW.
- UW, 0: user/ECC sideband width, stored alongside data; 0 means no user bits.
- IW, 20: request/response ID width.
- TS_BIT, 21: address bit that flags a test-and-set access.
- TS_VALUE, all-ones: word written by the set phase of a test-and-set.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- add_i  in  AW  byte address
- wen_i  in  1  1 = read, 0 = write (HCI convention)
- data_i  in  DW  write data
- user_i  in  max(UW,1)  write user bits; ignored when UW=0
- be_i  in  DW/BW  byte enables
- id_i  in  IW  request ID
- gnt_o  out  1  request accepted this cycle
- r_valid_o  out  1  response valid
- r_data_o  out  DW  read data
- r_user_o  out  max(UW,1)  read user bits; 0 when UW=0
- r_id_o  out  IW  response ID
- mem_req_o  out  1  SRAM chip enable
- mem_wen_o  out  1  SRAM read=1 / write=0
- mem_add_o  out  MEM_AW  SRAM word address
- mem_wdata_o  out  UW+DW  SRAM write word {user,data}
- mem_be_o  out  (UW+DW)/BW  SRAM byte enables; user bytes always enabled on writes
- mem_rdata_i  in  UW+DW  SRAM read word, valid one cycle after a read

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE.
  - r_id_o is 0.
  - No SRAM access is issued.
- FSM states: IDLE, TS_SET.
- IDLE:
  - gnt_o = 1 (combinational, independent of req_i).
  - On req_i, forward the request to the SRAM in the same cycle: mem_req_o = 1, mem_add_o = add_i[2 +: MEM_AW], wen/data/be passed through.
  - TS_BIT and bits above/below the word index are not used for addressing.
- Response timing:
  - Every granted request, read or write, produces exactly one r_valid_o pulse in the next cycle.
  - r_id_o = registered id_i of that request.
  - r_data_o / r_user_o = mem_rdata_i for reads; they are don't-care for writes and are driven from mem_rdata_i anyway.
  - Latency is fixed at 1 cycle.
  - Back-to-back requests are accepted every cycle with no bubbles.
- Test-and-set:
  - Triggered by req_i & wen_i & add_i[TS_BIT]. Cycle 0 is a normal read; go to TS_SET and latch the word address.
  - TS_SET:
    - gnt_o = 0.
    - mem_req_o = 1, mem_wen_o = 0, mem_add_o = latched address, mem_wdata_o = TS_VALUE, all byte enables set.
    - No r_valid is generated for the set phase.
    - Return to IDLE next cycle.
  - The r_valid for the TS read (old value) fires in the TS_SET cycle.
- A write with TS_BIT set (wen_i = 0) is a plain write.
- A request present during TS_SET is not granted. The initiator holds it and it is granted the following IDLE cycle. Strict ordering holds: a read to the same word after a TS returns TS_VALUE.
- req_i low: mem_req_o = 0 and no r_valid next cycle.
- r_id_o holds its last value when r_valid_o is 0.
- Reset asserted mid-TS: the FSM returns to IDLE, the set write is abandoned, and a pending r_valid is cleared.
- No internal buffering beyond the 1-deep response register and the TS address register.

Decomposition:
- hci_package:
  - hci_bank_state_e (IDLE, TS_SET).
  - Default TS_BIT constant, shared with the interconnect parameterisation so the two cannot diverge.
  - DEFAULT_DW/BW/UW as already defined.
- Module structure: single module. An optional wrapper hci_tcdm_bank_responder_intf adapts hci_core_intf.target to the flat ports. The SRAM macro is external.

Test Plan:
- Write 0xDEADBEEF with be=4'b1111 at add 0x40, id 5; then read 0x40, id 7 → two r_valid pulses at cycles +1 and +2; the second has r_data 0xDEADBEEF and r_id 7.
- Partial write be=4'b0010, data 0x0000AB00 over 0x11223344 → subsequent read returns 0x1122AB44.
- TS read at add 0x40 | (1<<21), word holds 0 → r_data 0, gnt_o low for exactly one cycle, SRAM write of 0xFFFFFFFF to word 0x10; a following read returns 0xFFFFFFFF.
- Read request held during TS_SET → gnt delayed one cycle, r_valid count equals grant count, data returns TS_VALUE.
- Continuous reads on 8 consecutive cycles → 8 r_valid pulses, each one cycle after its grant, with IDs matching in order.
- rst_ni asserted in the TS_SET cycle → no SRAM write, all outputs 0, and the next request is granted immediately after reset release.
